// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences PLL reset, qualifies lock, staggers per-domain
// reset release, retries or faults on timeout, and gates divider reprogramming.
module pll_lock_supervisor #(
  parameter int                   NUM_OUT          = 3,
  parameter int                   RST_HOLD_CYC     = 16,
  parameter int                   LOCK_TIMEOUT_CYC = 5000,
  parameter int                   STABLE_CYC       = 1024,
  parameter int                   LOSS_FILT        = 4,
  parameter int                   STAGGER_CYC      = 8,
  parameter int                   MAX_RETRY        = 3,
  parameter logic [NUM_OUT*10-1:0] INIT_RATIO      = {10'd88, 10'd25, 10'd7}
) (
  input  logic                  clkin1,
  input  logic                  rst,
  input  logic                  pll_lock,
  output logic                  pll_rst_o,
  output logic                  pll_pwd_o,
  output logic [NUM_OUT*10-1:0] ratio_o,
  output logic [NUM_OUT-1:0]    ch_rst,
  output logic                  lock_ok,
  input  logic                  cfg_valid,
  input  logic [2:0]            cfg_ch,
  input  logic [9:0]            cfg_ratio,
  output logic                  cfg_ready,
  output logic                  cfg_err,
  input  logic                  fault_clr,
  output logic                  fault,
  output logic [7:0]            lost_cnt
);

  localparam int CNT_MAX = LOCK_TIMEOUT_CYC + STABLE_CYC + RST_HOLD_CYC + STAGGER_CYC * NUM_OUT + 1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int FLT_MAX = (STABLE_CYC > LOSS_FILT) ? STABLE_CYC : LOSS_FILT;
  localparam int FLT_W   = $clog2(FLT_MAX + 1);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(RST_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT    = CNT_W'(LOCK_TIMEOUT_CYC);
  localparam logic [CNT_W-1:0]   STAG_END   = CNT_W'(STAGGER_CYC * NUM_OUT);
  localparam logic [FLT_W-1:0]   STABLE_LIM = FLT_W'(STABLE_CYC);
  localparam logic [FLT_W-1:0]   LOSS_LIM   = FLT_W'(LOSS_FILT);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);

  typedef enum logic [2:0] {S_HOLD, S_WAIT, S_STAB, S_LOCK, S_FAULT} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
  logic [FLT_W-1:0]        flt_q, flt_d, flt_inc;
  logic [RETRY_W-1:0]      retry_q, retry_d;
  logic [7:0]              lost_q, lost_d;
  logic [1:0]              sync_q, sync_d;
  logic [NUM_OUT*10-1:0]   ratio_q, ratio_d;
  logic                    pll_rst_q, pll_rst_d;
  logic                    pwd_q, pwd_d;
  logic [NUM_OUT-1:0]      ch_rst_q, ch_rst_d;
  logic                    lock_ok_q, lock_ok_d;
  logic                    cfg_ready_q, cfg_ready_d;
  logic                    cfg_err_q, cfg_err_d;
  logic                    fault_q, fault_d;
  logic                    lock_s, loss_evt, cfg_hs, cfg_ok;

  assign lock_s    = sync_q[1];
  assign pll_rst_o = pll_rst_q;
  assign pll_pwd_o = pwd_q;
  assign ratio_o   = ratio_q;
  assign ch_rst    = ch_rst_q;
  assign lock_ok   = lock_ok_q;
  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;
  assign fault     = fault_q;
  assign lost_cnt  = lost_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    flt_d     = flt_q;
    retry_d   = retry_q;
    lost_d    = lost_q;
    ratio_d   = ratio_q;
    cfg_err_d = 1'b0;
    sync_d    = {sync_q[0], pll_lock};
    cnt_inc   = cnt_q + CNT_W'(1);
    flt_inc   = flt_q + FLT_W'(1);
    loss_evt  = 1'b0;
    cfg_hs    = cfg_valid && cfg_ready_q;
    cfg_ok    = (int'(cfg_ch) < NUM_OUT) && (cfg_ratio != 10'd0);

    case (state_q)
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        if (lock_s) begin
          state_d = S_STAB;
          flt_d   = '0;
        end else if (cnt_inc >= TIMEOUT) begin
          cnt_d   = '0;
          retry_d = retry_q + RETRY_W'(1);
          state_d = (retry_q == RETRY_LAST) ? S_FAULT : S_HOLD;
        end
      end
      // The timeout count keeps running here so a bouncing lock cannot stall retries.
      S_STAB: begin
        cnt_d = cnt_inc;
        if (!lock_s) begin
          state_d = S_WAIT;
        end else if (flt_inc == STABLE_LIM) begin
          state_d = S_LOCK;
          cnt_d   = '0;
          flt_d   = '0;
          retry_d = '0;
        end else begin
          flt_d = flt_inc;
        end
      end
      S_LOCK: begin
        if (cnt_q != STAG_END) cnt_d = cnt_inc;
        if (lock_s) begin
          flt_d = '0;
        end else if (flt_inc == LOSS_LIM) begin
          loss_evt = 1'b1;
        end else begin
          flt_d = flt_inc;
        end
        // Lock loss wins over a simultaneous reconfiguration request.
        if (loss_evt) begin
          state_d = S_HOLD;
          cnt_d   = '0;
          flt_d   = '0;
          lost_d  = (lost_q == 8'hff) ? lost_q : lost_q + 8'd1;
        end else if (cfg_hs) begin
          if (cfg_ok) begin
            for (int k = 0; k < NUM_OUT; k++) begin
              if (int'(cfg_ch) == k) ratio_d[k*10 +: 10] = cfg_ratio;
            end
            state_d = S_HOLD;
            cnt_d   = '0;
            flt_d   = '0;
            retry_d = '0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_FAULT: begin
        if (fault_clr) begin
          state_d = S_HOLD;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
      default: begin
        state_d = S_HOLD;
        cnt_d   = '0;
      end
    endcase

    pll_rst_d   = (state_d == S_HOLD) || (state_d == S_FAULT);
    pwd_d       = (state_d == S_FAULT);
    fault_d     = (state_d == S_FAULT);
    lock_ok_d   = (state_d == S_LOCK);
    cfg_ready_d = (state_d == S_LOCK);
    for (int k = 0; k < NUM_OUT; k++) begin
      ch_rst_d[k] = !((state_d == S_LOCK) && (cnt_d >= CNT_W'(STAGGER_CYC * (k + 1))));
    end
  end

  always_ff @(posedge clkin1 or posedge rst) begin
    if (rst) begin
      state_q     <= S_HOLD;
      cnt_q       <= '0;
      flt_q       <= '0;
      retry_q     <= '0;
      lost_q      <= '0;
      sync_q      <= '0;
      ratio_q     <= INIT_RATIO;
      pll_rst_q   <= 1'b1;
      pwd_q       <= 1'b0;
      ch_rst_q    <= '1;
      lock_ok_q   <= 1'b0;
      cfg_ready_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      flt_q       <= flt_d;
      retry_q     <= retry_d;
      lost_q      <= lost_d;
      sync_q      <= sync_d;
      ratio_q     <= ratio_d;
      pll_rst_q   <= pll_rst_d;
      pwd_q       <= pwd_d;
      ch_rst_q    <= ch_rst_d;
      lock_ok_q   <= lock_ok_d;
      cfg_ready_q <= cfg_ready_d;
      cfg_err_q   <= cfg_err_d;
      fault_q     <= fault_d;
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed scenarios plus random lock/cfg traffic,
// every cycle compared against a phase/timer reference model.
module tb_pll_lock_supervisor;
  localparam int N = 3, RH = 4, TO = 50, SC = 8, LF = 4, SG = 2, MR = 3;
  localparam logic [29:0] INIT = {10'd88, 10'd25, 10'd7};
  localparam int PH_HOLD = 0, PH_WAIT = 1, PH_STAB = 2, PH_LOCK = 3, PH_FAULT = 4;

  logic        clk = 1'b0, rst = 1'b1, pll_lock = 1'b0;
  logic        cfg_valid = 1'b0, fault_clr = 1'b0;
  logic [2:0]  cfg_ch = 3'd0;
  logic [9:0]  cfg_ratio = 10'd0;
  logic        pll_rst_o, pll_pwd_o, lock_ok, cfg_ready, cfg_err, fault;
  logic [29:0] ratio_o;
  logic [2:0]  ch_rst;
  logic [7:0]  lost_cnt;

  pll_lock_supervisor #(
    .NUM_OUT(N), .RST_HOLD_CYC(RH), .LOCK_TIMEOUT_CYC(TO), .STABLE_CYC(SC),
    .LOSS_FILT(LF), .STAGGER_CYC(SG), .MAX_RETRY(MR), .INIT_RATIO(INIT)
  ) dut (
    .clkin1(clk), .rst(rst), .pll_lock(pll_lock), .pll_rst_o(pll_rst_o),
    .pll_pwd_o(pll_pwd_o), .ratio_o(ratio_o), .ch_rst(ch_rst), .lock_ok(lock_ok),
    .cfg_valid(cfg_valid), .cfg_ch(cfg_ch), .cfg_ratio(cfg_ratio),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .fault_clr(fault_clr),
    .fault(fault), .lost_cnt(lost_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: phase, time in phase, elapsed lock wait, run lengths.
  int         m_ph, m_t, m_wait, m_hi, m_lo, m_tries, m_lost;
  logic [9:0] m_ratio [N];
  bit         m_err, m_s1, m_s2;

  function automatic void m_reset();
    m_ph = PH_HOLD; m_t = 0; m_wait = 0; m_hi = 0; m_lo = 0; m_tries = 0; m_lost = 0;
    m_err = 0; m_s1 = 0; m_s2 = 0;
    for (int k = 0; k < N; k++) m_ratio[k] = INIT[k*10 +: 10];
  endfunction

  function automatic void m_step();
    bit ls;
    ls = m_s2; m_s2 = m_s1; m_s1 = pll_lock; m_err = 0;
    case (m_ph)
      PH_HOLD: begin
        m_t++;
        if (m_t == RH) begin m_ph = PH_WAIT; m_wait = 0; end
      end
      PH_WAIT: begin
        m_wait++;
        if (ls) begin m_ph = PH_STAB; m_hi = 0; end
        else if (m_wait >= TO) begin
          m_tries++;
          m_ph = (m_tries == MR) ? PH_FAULT : PH_HOLD;
          m_t = 0;
        end
      end
      PH_STAB: begin
        m_wait++;
        if (!ls) m_ph = PH_WAIT;
        else begin
          m_hi++;
          if (m_hi == SC) begin m_ph = PH_LOCK; m_t = 0; m_lo = 0; m_tries = 0; end
        end
      end
      PH_LOCK: begin
        m_t++;
        m_lo = ls ? 0 : m_lo + 1;
        if (m_lo == LF) begin
          if (m_lost < 255) m_lost++;
          m_ph = PH_HOLD; m_t = 0;
        end else if (cfg_valid) begin
          if (cfg_ch < N && cfg_ratio != 0) begin
            m_ratio[cfg_ch] = cfg_ratio;
            m_ph = PH_HOLD; m_t = 0; m_tries = 0;
          end else m_err = 1;
        end
      end
      default: begin
        if (fault_clr) begin m_tries = 0; m_ph = PH_HOLD; m_t = 0; end
      end
    endcase
  endfunction

  task automatic check_outputs();
    logic [2:0] ec;
    for (int k = 0; k < N; k++) ec[k] = !(m_ph == PH_LOCK && m_t >= SG * (k + 1));
    chk("pll_rst_o", pll_rst_o, (m_ph == PH_HOLD || m_ph == PH_FAULT));
    chk("pll_pwd_o", pll_pwd_o, (m_ph == PH_FAULT));
    chk("fault", fault, (m_ph == PH_FAULT));
    chk("lock_ok", lock_ok, (m_ph == PH_LOCK));
    chk("cfg_ready", cfg_ready, (m_ph == PH_LOCK));
    chk("cfg_err", cfg_err, m_err);
    chk("ch_rst", ch_rst, ec);
    chk("lost_cnt", lost_cnt, m_lost);
    chk("ratio_o", ratio_o, {m_ratio[2], m_ratio[1], m_ratio[0]});
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) m_reset(); else m_step();
    @(negedge clk);
    check_outputs();
    cfg_valid = 1'b0;
    fault_clr = 1'b0;
  endtask

  task automatic wait_lock(input string tag);
    int n;
    n = 0;
    do begin tick(); n++; end while (!lock_ok && n < 200);
    chk(tag, lock_ok, 1'b1);
  endtask

  task automatic stagger_check(input string tag);
    int rel [N];
    int n;
    for (int k = 0; k < N; k++) rel[k] = 0;
    n = 0;
    do begin
      tick(); n++;
      for (int k = 0; k < N; k++) if (!ch_rst[k] && rel[k] == 0) rel[k] = n;
    end while (ch_rst != 3'b000 && n < 40);
    for (int k = 0; k < N; k++) chk(tag, rel[k], SG * (k + 1));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    m_reset();
    check_outputs();
    tick(); tick();
    rst = 1'b0;
  endtask

  int n, t_rl, lvl, run;
  bit dropped;

  initial begin
    m_reset();
    // Reset state, then lock from release
    pll_lock = 1'b1;
    tick(); tick();
    chk("rst_ch_rst", ch_rst, 3'b111);
    chk("rst_ratio", ratio_o, INIT);
    rst = 1'b0;
    n = 0; t_rl = 0;
    do begin
      tick(); n++;
      if (!pll_rst_o && t_rl == 0) t_rl = n;
    end while (!lock_ok && n < 200);
    chk("pll_rst_release", t_rl, RH);
    chk("lock_latency", n, RH + 1 + SC);
    stagger_check("stagger_first");

    // Short glitch ignored, filtered loss triggers relock
    dropped = 0;
    pll_lock = 1'b0;
    repeat (3) begin tick(); if (!lock_ok) dropped = 1; end
    pll_lock = 1'b1;
    repeat (6) begin tick(); if (!lock_ok) dropped = 1; end
    chk("glitch_no_effect", dropped, 1'b0);
    pll_lock = 1'b0;
    repeat (4) tick();
    pll_lock = 1'b1;
    repeat (4) tick();
    chk("loss_ch_rst", ch_rst, 3'b111);
    chk("loss_lost_cnt", lost_cnt, 8'd1);
    wait_lock("relock_after_loss");
    stagger_check("stagger_after_loss");

    // Reconfiguration: valid, then rejected requests
    cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_ratio = 10'd40;
    tick();
    chk("cfg_ratio_ch1", ratio_o[19:10], 10'd40);
    chk("cfg_pll_rst", pll_rst_o, 1'b1);
    wait_lock("relock_after_cfg");
    stagger_check("stagger_after_cfg");
    cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_ratio = 10'd0;
    tick();
    chk("cfg_zero_err", cfg_err, 1'b1);
    chk("cfg_zero_ratio", ratio_o, {10'd88, 10'd40, 10'd7});
    tick();
    chk("cfg_err_pulse_end", cfg_err, 1'b0);
    cfg_valid = 1'b1; cfg_ch = 3'd6; cfg_ratio = 10'd5;
    tick();
    chk("cfg_badch_err", cfg_err, 1'b1);
    chk("cfg_badch_locked", lock_ok, 1'b1);

    // Loss and valid cfg in the same cycle
    pll_lock = 1'b0;
    n = 0;
    while (!(m_ph == PH_LOCK && m_lo == LF - 1 && !m_s2) && n < 20) begin tick(); n++; end
    cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_ratio = 10'd99;
    tick();
    chk("coll_ratio_ch0", ratio_o[9:0], 10'd7);
    chk("coll_cfg_err", cfg_err, 1'b0);
    chk("coll_lost_cnt", lost_cnt, 8'd2);
    pll_lock = 1'b1;
    wait_lock("relock_after_coll");

    // Reset mid-stagger
    repeat (3) tick();
    chk("pre_rst_ch_rst", ch_rst, 3'b110);
    pll_lock = 1'b0;
    pulse_reset();
    chk("midrst_ratio", ratio_o, INIT);
    chk("midrst_lost", lost_cnt, 8'd0);

    // Timeouts into FAULT, then clear
    n = 0;
    do begin tick(); n++; end while (!fault && n < 400);
    chk("fault_latency", n, MR * (RH + TO));
    chk("fault_pwd", pll_pwd_o, 1'b1);
    repeat (5) tick();
    fault_clr = 1'b1; pll_lock = 1'b1;
    tick();
    wait_lock("relock_after_fault");

    // Random traffic
    run = 0; lvl = 1;
    for (int i = 0; i < 2500; i++) begin
      if (run == 0) begin
        if ($urandom_range(0, 9) < 7) begin lvl = 1; run = $urandom_range(10, 120); end
        else begin
          lvl = 0;
          run = ($urandom_range(0, 3) == 0) ? $urandom_range(40, 200) : $urandom_range(1, 6);
        end
      end
      pll_lock = (lvl != 0);
      run--;
      if ($urandom_range(0, 19) == 0) begin
        cfg_valid = 1'b1;
        cfg_ch = 3'($urandom_range(0, 4));
        cfg_ratio = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
      end
      if ($urandom_range(0, 29) == 0) fault_clr = 1'b1;
      if ($urandom_range(0, 799) == 0) pulse_reset();
      else tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
